seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Refresh scanner that sits directly upstream of the seven-segment decoder-with-enable.
- Holds a 4-digit hex value and time-multiplexes it onto the decoder's 2-bit digit-select (en) and 4-bit nibble (num) inputs at a programmable refresh rate.
- New values arrive through a valid/ready load port, are buffered, and are committed only at frame boundaries, so a displayed frame never tears.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range >= 2.
- CNT_W, $clog2(REFRESH_DIV), prescaler counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- value_in  input  16  hex value to display; [15:12] is the leftmost digit.
- load_valid  input  1  value_in is valid this cycle.
- load_ready  output  1  block can accept a value.
- en  output  2  digit select to decoder; registered.
- num  output  4  nibble for the currently selected digit.
- frame_tick  output  1  one-cycle pulse at each frame start; registered.
- digit_blank  output  1  current digit is to be blanked (see Optional Feature).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - prescaler = 0, en = 0, display register = 0x0000, pending empty.
  - Therefore num = 0, frame_tick = 0, digit_blank = 0, load_ready = 1.
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - On the edge where count == REFRESH_DIV-1, the count returns to 0 and en increments modulo 4 (3 -> 0 wraps).
  - Each digit slot is exactly REFRESH_DIV cycles.
- Digit mapping:
  - en=0 -> disp[15:12], en=1 -> disp[11:8], en=2 -> disp[7:4], en=3 -> disp[3:0].
  - num is combinational from the registered en and display register; no extra latency.
- Load handshake:
  - load_ready = !pend_full.
  - Transfer occurs when load_valid && load_ready; value_in is captured into the pending register and pend_full is set.
  - value_in is ignored while load_ready = 0; the source must hold load_valid.
- Commit:
  - On the edge where en wraps 3 -> 0, if pend_full, then disp <= pending and pend_full is cleared.
  - load_ready therefore rises in the first cycle of the new frame.
  - num shows the new value's [15:12] in that same cycle.
- Simultaneous events:
  - An accept on the wrap edge (pending previously empty) is not bypassed; it commits at the next frame boundary.
  - Accept and commit of the same entry on one edge is impossible, since ready was low while full.
- frame_tick is high for exactly the first cycle of en=0 after each wrap.
  - It also fires when nothing is committed.
  - It does not fire on the first frame after reset.
- Reset mid-operation:
  - Any pending value is discarded and the display returns to 0.
  - No partial frame is completed.
- No state machine beyond the 2-bit digit counter and the 1-bit pending flag.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- When defined:
  - digit_blank = 1 when the current digit and every more-significant digit of disp are zero.
  - en=3 (least-significant digit) is never blanked.
  - digit_blank is combinational from en and disp.
- When undefined:
  - digit_blank is tied to 0.
  - The port still exists, so the interface is unchanged.

Decomposition:
- Package seg_disp_pkg:
  - DIGITS = 4, NIBBLE_W = 4, DISP_W = 16.
  - typedef digit_idx_t (2-bit).
- Sub-module seg_refresh_prescaler (parameter REFRESH_DIV) outputs a one-cycle slot_tick; the top-level owns en, the pending/display registers and the handshake.

Test Plan (REFRESH_DIV=4):
1. Reset behaviour:
   - Stimulus: hold rst_n low, then release.
   - Required during reset: en=0, num=0, load_ready=1, frame_tick=0.
   - Required after release: en steps 0,1,2,3,0 every 4 clocks; frame_tick pulses once at the wrap.
2. Single load:
   - Stimulus: load 0x1234 during en=1.
   - Required: load_ready=0 on the next cycle; num continues showing 0.
   - Required at wrap: num shows 1,2,3,4 across slots and load_ready=1 in the first cycle of en=0.
3. Back-to-back loads:
   - Stimulus: 0xAAAA is accepted; 0xBBBB is then presented with load_valid held.
   - Required: 0xBBBB stalls until the 0xAAAA commit; it is accepted in that first cycle and displayed one full frame later.
4. Load on the wrap edge:
   - Stimulus: load 0x5678 on the cycle en goes 3 -> 0, with pending empty.
   - Required: the display keeps its old value for the whole frame; 0x5678 appears at the following frame.
5. Reset mid-operation:
   - Stimulus: assert rst_n with 0x9999 pending and en=2.
   - Required: immediate en=0, num=0, load_ready=1; 0x9999 never appears.
6. Leading-zero blanking:
   - With SEG_LZ_BLANK_EN and value 0x0040: digit_blank = 1,1,0,0 over en=0..3.
   - With SEG_LZ_BLANK_EN and value 0x0000: digit_blank = 1,1,1,0.
   - Without SEG_LZ_BLANK_EN: digit_blank = 0 always.

Source files
------------

// File: rtl/seg_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_disp_pkg
//  Purpose  : Shared widths, types and a nibble-select helper for the
//             seven-segment refresh scanner.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package seg_disp_pkg;

    localparam int DIGITS   = 4;
    localparam int NIBBLE_W = 4;
    localparam int DISP_W   = 16;

    typedef logic [1:0]          digit_idx_t;
    typedef logic [DISP_W-1:0]   disp_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Digit index 0 is the leftmost (most-significant) nibble.
    function automatic nibble_t digit_of(input disp_t d, input digit_idx_t idx);
        disp_t s;
        s = d >> (NIBBLE_W * (DIGITS - 1 - int'(idx)));
        return s[NIBBLE_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl_if
//  Purpose  : Load handshake and decoder-side outputs of the refresh scanner.
//  Signals  : value_in[15:0], load_valid  (source -> scanner)
//             load_ready                  (scanner -> source)
//             en[1:0], num[3:0], frame_tick, digit_blank (scanner -> decoder)
//  Modports : master = value source / observer, slave = scanner
//  Revision : 1.0  initial release
// ============================================================================
interface seg_scan_ctrl_if;
    import seg_disp_pkg::*;

    disp_t      value_in;
    logic       load_valid;
    logic       load_ready;
    digit_idx_t en;
    nibble_t    num;
    logic       frame_tick;
    logic       digit_blank;

    modport master (
        output value_in, load_valid,
        input  load_ready, en, num, frame_tick, digit_blank
    );

    modport slave (
        input  value_in, load_valid,
        output load_ready, en, num, frame_tick, digit_blank
    );
endinterface
`default_nettype wire

// File: rtl/seg_refresh_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : seg_refresh_prescaler
//  Purpose  : Free-running 0..REFRESH_DIV-1 counter; slot_tick_o is high in
//             the last cycle of each digit slot, so the edge that ends the
//             slot sees it asserted.
//  Ports    : clk, rst_n (async, active low), slot_tick_o
//  Revision : 1.0  initial release
// ============================================================================
module seg_refresh_prescaler #(
    parameter int  REFRESH_DIV = 100000,
    localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  wire logic clk,
    input  wire logic rst_n,
    output logic      slot_tick_o
);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    always_comb begin
        slot_tick_o = (cnt_q == c_last);
        cnt_d       = slot_tick_o ? '0 : cnt_q + CNT_W'(1);
    end
endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexes a buffered 4-digit hex value onto a seven-
//             segment decoder. New values are held in a one-entry pending
//             register and committed only when the digit counter wraps
//             3 -> 0, so a frame never shows a mix of two values.
//  Ports    : clk, rst_n (async, active low)
//             bus (slave): value_in, load_valid, load_ready, en, num,
//                          frame_tick, digit_blank
//  Options  : SEG_LZ_BLANK_EN - when defined, digit_blank flags leading-zero
//             digits (the rightmost digit is never blanked); otherwise 0.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl
    import seg_disp_pkg::*;
#(
    parameter int  REFRESH_DIV = 100000,
    localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam digit_idx_t c_last_digit = digit_idx_t'(DIGITS - 1);

    logic       w_slot_tick;
    logic       w_wrap;
    logic       w_accept;
    logic       w_blank;

    digit_idx_t en_q, en_d;
    disp_t      disp_q, disp_d;
    disp_t      pend_q, pend_d;
    logic       pend_full_q, pend_full_d;
    logic       frame_tick_q, frame_tick_d;

    seg_refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .slot_tick_o (w_slot_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q         <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            en_q         <= en_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        w_wrap       = w_slot_tick && (en_q == c_last_digit);
        w_accept     = bus.load_valid && !pend_full_q;
        en_d         = en_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        frame_tick_d = w_wrap;

        if (w_slot_tick) begin
            en_d = en_q + digit_idx_t'(1);
        end
        // Commit and accept are mutually exclusive: accept needs the pending
        // slot empty, commit needs it full. An accept on the wrap edge
        // therefore waits for the next frame boundary.
        if (w_wrap && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (w_accept) begin
            pend_d      = bus.value_in;
            pend_full_d = 1'b1;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    // Blank when this digit and all digits to its left are zero.
    always_comb begin
        w_blank = (en_q != c_last_digit);
        for (int i = 0; i < DIGITS; i++) begin
            if ((i <= int'(en_q)) && (digit_of(disp_q, digit_idx_t'(i)) != '0)) begin
                w_blank = 1'b0;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    assign bus.load_ready  = !pend_full_q;
    assign bus.en          = en_q;
    assign bus.num         = digit_of(disp_q, en_q);
    assign bus.frame_tick  = frame_tick_q;
    assign bus.digit_blank = w_blank;
endmodule
`default_nettype wire
